// File: rtl/slot_pkg.sv
// Shared types for the slot machine reel judge.
package slot_pkg;

    localparam int unsigned NUM_REELS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        JUDGE = 2'd2,
        SHOW  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PAIR    = 2'd1,
        TRIPLE  = 2'd2,
        JACKPOT = 2'd3
    } res_t;

endpackage

// File: rtl/slot_reel_latch.sv
// One reel's enable flop and latched symbol. Accept wins over arm.
module slot_reel_latch #(
    parameter int unsigned CW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          accept,
    input  logic [CW-1:0] count,
    output logic          en,
    output logic [CW-1:0] sym
);

    // Enable set at game start, cleared with a symbol capture on stop
    always_ff @(posedge clock) begin
        if (reset) begin
            en  <= 1'b0;
            sym <= '0;
        end else if (accept) begin
            en  <= 1'b0;
            sym <= count;
        end else if (arm) begin
            en  <= 1'b1;
        end
    end

endmodule

// File: rtl/slot_reel_judge.sv
// Slot machine reel judge: runs the three reel counters, latches the
// stopped symbols and scores the combination.
// Optional feature: define SLOT_AUTO_STOP_EN to force-stop reels one per
// cycle (lowest index first) once the spin has lasted AUTO_STOP_CYCLES.
module slot_reel_judge
    import slot_pkg::*;
#(
    parameter int unsigned CW               = 3,
    parameter int unsigned MIN_SPIN         = 16,
    parameter int unsigned JACKPOT_SYM      = 7,
    parameter int unsigned AUTO_STOP_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_REELS-1:0] stop_btn,
    input  logic [CW-1:0]        count0,
    input  logic [CW-1:0]        count1,
    input  logic [CW-1:0]        count2,
    output logic [NUM_REELS-1:0] reel_en,
    output logic [CW-1:0]        sym0,
    output logic [CW-1:0]        sym1,
    output logic [CW-1:0]        sym2,
    output logic                 busy,
    output logic                 result_valid,
    output res_t                 result
);

    localparam int unsigned SPAN = (MIN_SPIN > AUTO_STOP_CYCLES) ? MIN_SPIN : AUTO_STOP_CYCLES;
    localparam int unsigned SCW  = $clog2(SPAN + 1);

    state_t                 state;
    state_t                 state_n;
    logic [SCW-1:0]         spin_cnt;
    logic [NUM_REELS-1:0]   arm;
    logic [NUM_REELS-1:0]   accept;
    logic                   stops_open;
    res_t                   judged;
`ifdef SLOT_AUTO_STOP_EN
    logic [NUM_REELS-1:0]   force_stop;
`endif

    // Per-reel enable and symbol storage
    slot_reel_latch #(.CW(CW)) u_reel0 (
        .clock(clock), .reset(reset), .arm(arm[0]), .accept(accept[0]),
        .count(count0), .en(reel_en[0]), .sym(sym0)
    );
    slot_reel_latch #(.CW(CW)) u_reel1 (
        .clock(clock), .reset(reset), .arm(arm[1]), .accept(accept[1]),
        .count(count1), .en(reel_en[1]), .sym(sym1)
    );
    slot_reel_latch #(.CW(CW)) u_reel2 (
        .clock(clock), .reset(reset), .arm(arm[2]), .accept(accept[2]),
        .count(count2), .en(reel_en[2]), .sym(sym2)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, reel arming and stop acceptance
    always_comb begin
        state_n    = state;
        arm        = '0;
        accept     = '0;
        stops_open = (spin_cnt >= SCW'(MIN_SPIN));
`ifdef SLOT_AUTO_STOP_EN
        force_stop = '0;
`endif
        case (state)
            IDLE, SHOW: begin
                if (start) begin
                    state_n = SPIN;
                    arm     = '1;
                end
            end
            SPIN: begin
                accept = reel_en & stop_btn & {NUM_REELS{stops_open}};
`ifdef SLOT_AUTO_STOP_EN
                // Isolate the lowest running reel
                force_stop = reel_en & (~reel_en + NUM_REELS'(1));
                if (spin_cnt >= SCW'(AUTO_STOP_CYCLES)) begin
                    accept = accept | force_stop;
                end
`endif
                if ((reel_en & ~accept) == '0) begin
                    state_n = JUDGE;
                end
            end
            JUDGE: begin
                state_n = SHOW;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Spin duration counter, cleared on game start, saturating
    always_ff @(posedge clock) begin
        if (reset) begin
            spin_cnt <= '0;
        end else if ((state == IDLE || state == SHOW) && start) begin
            spin_cnt <= '0;
        end else if (state == SPIN && spin_cnt != '1) begin
            spin_cnt <= spin_cnt + SCW'(1);
        end
    end

    // Score the latched symbols (full-width equality)
    always_comb begin
        judged = NONE;
        if (sym0 == sym1 && sym1 == sym2) begin
            judged = (sym0 == CW'(JACKPOT_SYM)) ? JACKPOT : TRIPLE;
        end else if (sym0 == sym1 || sym1 == sym2 || sym0 == sym2) begin
            judged = PAIR;
        end
    end

    // Registered status and result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= NONE;
        end else begin
            busy         <= (state_n == SPIN) || (state_n == JUDGE);
            result_valid <= (state_n == SHOW);
            if (state == JUDGE) begin
                result <= judged;
            end else if (state_n == SPIN) begin
                result <= NONE;
            end
        end
    end

endmodule

// File: tb/tb_slot_reel_judge.sv
// Bench for slot_reel_judge: reference model compared every cycle plus
// literal expectations along directed game scenarios.
module tb_slot_reel_judge;

    localparam int unsigned CW          = 3;
    localparam int unsigned MIN_SPIN    = 16;
    localparam int unsigned JACKPOT_SYM = 7;
    localparam int unsigned AUTO_STOP   = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    stop_btn;
    logic [CW-1:0] count0, count1, count2;
    logic [2:0]    reel_en;
    logic [CW-1:0] sym0, sym1, sym2;
    logic          busy, result_valid;
    logic [1:0]    result;

    int checks_m = 0, errors_m = 0;
    int checks_l = 0, errors_l = 0;
    bit cmp_on = 1'b0;

    slot_reel_judge #(
        .CW(CW), .MIN_SPIN(MIN_SPIN), .JACKPOT_SYM(JACKPOT_SYM), .AUTO_STOP_CYCLES(AUTO_STOP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop_btn(stop_btn),
        .count0(count0), .count1(count1), .count2(count2),
        .reel_en(reel_en), .sym0(sym0), .sym1(sym1), .sym2(sym2),
        .busy(busy), .result_valid(result_valid), .result(result)
    );

    always #5 clock = ~clock;

    // Reference model: game phase, running reels, symbols, score
    int            m_phase;     // 0 idle, 1 spin, 2 judge, 3 show
    int            m_elapsed;   // cycles spent spinning before this edge
    logic [2:0]    m_en;
    logic [CW-1:0] m_sym [3];
    logic [1:0]    m_res;

    // Score by counting equal pairs: 3 -> triple/jackpot, 1 -> pair, 0 -> none
    function automatic logic [1:0] score(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
        int n;
        n = int'(a == b) + int'(b == c) + int'(a == c);
        if (n == 3) return (a == CW'(JACKPOT_SYM)) ? 2'd3 : 2'd2;
        if (n == 1) return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge clock) begin : model
        logic [2:0]    take;
        logic [CW-1:0] cnt [3];
        cnt[0] = count0;
        cnt[1] = count1;
        cnt[2] = count2;
        take   = 3'b000;
        if (reset) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_en      = 3'b000;
            m_res     = 2'd0;
            for (int i = 0; i < 3; i++) m_sym[i] = '0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (start) begin
                m_phase   = 1;
                m_en      = 3'b111;
                m_elapsed = 0;
                m_res     = 2'd0;
            end
        end else if (m_phase == 1) begin
            for (int i = 0; i < 3; i++)
                if (stop_btn[i] && m_en[i] && m_elapsed >= int'(MIN_SPIN)) take[i] = 1'b1;
`ifdef SLOT_AUTO_STOP_EN
            if (m_elapsed >= int'(AUTO_STOP)) begin
                for (int i = 0; i < 3; i++)
                    if (m_en[i]) begin
                        take[i] = 1'b1;
                        break;
                    end
            end
`endif
            for (int i = 0; i < 3; i++)
                if (take[i]) begin
                    m_sym[i] = cnt[i];
                    m_en[i]  = 1'b0;
                end
            m_elapsed++;
            if (m_en == 3'b000) m_phase = 2;
        end else begin
            m_phase = 3;
            m_res   = score(m_sym[0], m_sym[1], m_sym[2]);
        end
    end

    task automatic mchk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks_m++;
        if (act !== exp) begin
            errors_m++;
            $display("FAIL model %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (cmp_on) begin
            mchk("reel_en", 8'(reel_en), 8'(m_en));
            mchk("sym0", 8'(sym0), 8'(m_sym[0]));
            mchk("sym1", 8'(sym1), 8'(m_sym[1]));
            mchk("sym2", 8'(sym2), 8'(m_sym[2]));
            mchk("busy", 8'(busy), 8'(m_phase == 1 || m_phase == 2));
            mchk("result_valid", 8'(result_valid), 8'(m_phase == 3));
            mchk("result", 8'(result), 8'(m_res));
        end
    end

    task automatic lchk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks_l++;
        if (act !== exp) begin
            errors_l++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop(input logic [2:0] b);
        stop_btn = b;
        tick();
        stop_btn = 3'b000;
    endtask

    // One full game with button stops at spin_cnt 16, 17, 18
    task automatic play(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                        input logic [CW-1:0] c2, input logic [1:0] exp, input string nm);
        pulse_start();
        lchk({nm, "_start_rv"}, 8'(result_valid), 8'd0);
        lchk({nm, "_start_res"}, 8'(result), 8'd0);
        repeat (MIN_SPIN) tick();
        count0 = c0; pulse_stop(3'b001);
        count1 = c1; pulse_stop(3'b010);
        count2 = c2; pulse_stop(3'b100);
        lchk({nm, "_judge_busy"}, 8'(busy), 8'd1);
        lchk({nm, "_judge_rv"}, 8'(result_valid), 8'd0);
        tick();
        lchk({nm, "_rv"}, 8'(result_valid), 8'd1);
        lchk({nm, "_res"}, 8'(result), 8'(exp));
        lchk({nm, "_busy"}, 8'(busy), 8'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop_btn = 3'b000;
        count0 = '0; count1 = '0; count2 = '0;
        tick(); tick();
        cmp_on = 1'b1;
        lchk("rst_reel_en", 8'(reel_en), 8'd0);
        lchk("rst_busy", 8'(busy), 8'd0);
        lchk("rst_rv", 8'(result_valid), 8'd0);
        lchk("rst_result", 8'(result), 8'd0);
        reset = 1'b0;
        tick();

        // Start arms all reels
        pulse_start();
        lchk("start_reel_en", 8'(reel_en), 8'h7);
        lchk("start_busy", 8'(busy), 8'd1);
        lchk("start_rv", 8'(result_valid), 8'd0);

        // Early stop dropped, later stop accepted, repeat stop ignored
        repeat (5) tick();
        count0 = 3'd4; pulse_stop(3'b001);
        lchk("early_stop_reel_en", 8'(reel_en), 8'h7);
        repeat (14) tick();
        pulse_stop(3'b001);
        lchk("stop0_sym0", 8'(sym0), 8'd4);
        lchk("stop0_reel_en", 8'(reel_en), 8'h6);
        count0 = 3'd6; pulse_stop(3'b001);
        lchk("restop_sym0", 8'(sym0), 8'd4);
        pulse_start();
        lchk("start_in_spin", 8'(reel_en), 8'h6);
        count1 = 3'd4; count2 = 3'd1; pulse_stop(3'b110);
        lchk("dual_reel_en", 8'(reel_en), 8'h0);
        tick();
        lchk("g0_res", 8'(result), 8'd1);
        repeat (3) tick();
        lchk("g0_hold_rv", 8'(result_valid), 8'd1);
        lchk("g0_hold_sym1", 8'(sym1), 8'd4);

        // Scoring
        play(3'd7, 3'd7, 3'd7, 2'd3, "jackpot");
        play(3'd2, 3'd2, 3'd2, 2'd2, "triple");
        play(3'd1, 3'd5, 3'd1, 2'd1, "pair");
        play(3'd0, 3'd3, 3'd6, 2'd0, "none");

        // Simultaneous stops, boundary at MIN_SPIN-1 vs MIN_SPIN
        pulse_start();
        repeat (MIN_SPIN - 1) tick();
        count0 = 3'd3; count1 = 3'd3; count2 = 3'd5;
        pulse_stop(3'b111);
        lchk("stop_at_15", 8'(reel_en), 8'h7);
        pulse_stop(3'b111);
        lchk("all_reel_en", 8'(reel_en), 8'h0);
        lchk("all_sym0", 8'(sym0), 8'd3);
        lchk("all_sym2", 8'(sym2), 8'd5);
        lchk("all_busy", 8'(busy), 8'd1);
        tick();
        lchk("all_res", 8'(result), 8'd1);
        lchk("all_rv", 8'(result_valid), 8'd1);

        // Reset mid-spin
        pulse_start();
        repeat (MIN_SPIN) tick();
        count0 = 3'd2; pulse_stop(3'b001);
        lchk("pre_rst_reel_en", 8'(reel_en), 8'h6);
        reset = 1'b1; tick(); reset = 1'b0;
        lchk("mid_rst_reel_en", 8'(reel_en), 8'h0);
        lchk("mid_rst_sym0", 8'(sym0), 8'd0);
        lchk("mid_rst_busy", 8'(busy), 8'd0);
        lchk("mid_rst_res", 8'(result), 8'd0);
        repeat (20) tick();
        lchk("idle_no_start", 8'(reel_en), 8'h0);
        play(3'd6, 3'd6, 3'd6, 2'd2, "replay");

`ifdef SLOT_AUTO_STOP_EN
        // Forced stops on consecutive cycles from spin_cnt == AUTO_STOP
        count0 = 3'd2; count1 = 3'd2; count2 = 3'd2;
        pulse_start();
        repeat (AUTO_STOP) tick();
        lchk("auto_before", 8'(reel_en), 8'h7);
        tick();
        lchk("auto_r0", 8'(reel_en), 8'h6);
        tick();
        lchk("auto_r1", 8'(reel_en), 8'h4);
        tick();
        lchk("auto_r2", 8'(reel_en), 8'h0);
        tick();
        lchk("auto_rv", 8'(result_valid), 8'd1);
        lchk("auto_res", 8'(result), 8'd2);
`else
        // No timeout: reels keep spinning past counter saturation
        pulse_start();
        repeat (300) tick();
        lchk("no_auto_reel_en", 8'(reel_en), 8'h7);
        lchk("no_auto_busy", 8'(busy), 8'd1);
        count0 = 3'd0; count1 = 3'd1; count2 = 3'd2;
        pulse_stop(3'b111);
        tick();
        lchk("late_res", 8'(result), 8'd0);
        lchk("late_rv", 8'(result_valid), 8'd1);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks_m + checks_l, errors_m + errors_l);
        $finish;
    end

endmodule
